// File: rtl/multi_wave_gen.sv
// N-channel pattern-replay waveform generator: every channel shares one bit
// sequencer, so all channel edges stay phase-aligned.
module multi_wave_gen #(
  parameter int CH    = 3,
  parameter int DEPTH = 32,
  parameter int DIV_W = 8,
  localparam int LEN_W = $clog2(DEPTH) + 1,
  localparam int CHW   = $clog2(CH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [CHW-1:0]   cfg_ch,
  input  logic [DEPTH-1:0] cfg_data,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             loop_mode,
  input  logic             start,
  input  logic             stop,
  output logic [CH-1:0]    wave,
  output logic             busy,
  output logic             done
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic {IDLE, RUN} state_e;

  state_e           state_q;
  logic [DEPTH-1:0] pattern_q [CH];
  logic [IDX_W-1:0] idx_q;
  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] div_q;
  logic [LEN_W-1:0] len_q;
  logic             loop_q;
  logic [CH-1:0]    wave_q;
  logic             busy_q;
  logic             done_q;

  logic [IDX_W-1:0] nextIdx_d;
  logic [CH-1:0]    firstBits_d;
  logic [CH-1:0]    nextBits_d;
  logic             lastBit_d;
  logic             lenOk_d;

  always_comb begin
    nextIdx_d   = idx_q + 1'b1;
    lastBit_d   = ({1'b0, idx_q} == (len_q - 1'b1));
    lenOk_d     = (cfg_len != '0) && (cfg_len <= LEN_W'(DEPTH));
    firstBits_d = '0;
    nextBits_d  = '0;
    for (int i = 0; i < CH; i++) begin
      firstBits_d[i] = pattern_q[i][0];
      nextBits_d[i]  = pattern_q[i][nextIdx_d];
    end
  end

  // The bit that is loaded on an edge is held for div+1 cycles, so the final
  // bit also gets its full period before the one-shot drops back to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      for (int i = 0; i < CH; i++) pattern_q[i] <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      div_q   <= '0;
      len_q   <= '0;
      loop_q  <= 1'b0;
      wave_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          wave_q <= '0;
          busy_q <= 1'b0;
          if (cfg_we) begin
            for (int i = 0; i < CH; i++) begin
              if (cfg_ch == CHW'(i)) pattern_q[i] <= cfg_data;
            end
          end
          if (start && !stop && lenOk_d) begin
            len_q   <= cfg_len;
            div_q   <= cfg_div;
            loop_q  <= loop_mode;
            idx_q   <= '0;
            cnt_q   <= '0;
            wave_q  <= firstBits_d;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (stop) begin
            state_q <= IDLE;
            wave_q  <= '0;
            busy_q  <= 1'b0;
          end else if (cnt_q == div_q) begin
            cnt_q <= '0;
            if (!lastBit_d) begin
              idx_q  <= nextIdx_d;
              wave_q <= nextBits_d;
            end else if (loop_q) begin
              idx_q  <= '0;
              wave_q <= firstBits_d;
            end else begin
              state_q <= IDLE;
              wave_q  <= '0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wave = wave_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
